// File: rtl/delay_allocator_pkg.sv
// Shared types and defaults for the delay-line allocator: FSM encoding and
// the default delay-RAM / descriptor geometry.
package delay_allocator_pkg;

  localparam int DELAY_MEM_ADDR_WIDTH = 16;
  localparam int DELAY_N_DELAYS       = 16;
  localparam int DELAY_DATA_WIDTH     = 16;
  localparam int DELAY_REQ_WIDTH      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    CLEAR = 2'd2,
    DESC  = 2'd3
  } alloc_state_t;

endpackage

// File: rtl/delay_allocator_if.sv
// Controller <-> allocator bundle: request/reset pulses in, clear-write and
// descriptor-write strobes out.
interface delay_allocator_if #(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int N_DELAYS       = 16,
  parameter int DATA_WIDTH     = 16
);
  localparam int IDX_W = (N_DELAYS > 1) ? $clog2(N_DELAYS) : 1;

  // Handshake: alloc_delay is a one-cycle pulse qualified by delay_size_in /
  // init_delay_in in the same cycle; it is accepted only while busy is low,
  // otherwise dropped with a one-cycle alloc_error. mem_clr_we and desc_we are
  // fire-and-forget write strobes with no back-pressure.
  logic [1:0]                alloc_delay;
  logic [31:0]               delay_size_in;
  logic [31:0]               init_delay_in;
  logic [1:0]                pipeline_full_reset;
  logic                      busy;
  logic                      alloc_error;
  logic                      mem_clr_we;
  logic [MEM_ADDR_WIDTH-1:0] mem_clr_addr;
  logic [DATA_WIDTH-1:0]     mem_clr_data;
  logic                      desc_we;
  logic                      desc_pipeline;
  logic [IDX_W-1:0]          desc_index;
  logic [MEM_ADDR_WIDTH-1:0] desc_base;
  logic [MEM_ADDR_WIDTH-1:0] desc_size;
  logic [MEM_ADDR_WIDTH-1:0] desc_init;

  modport master (
    output alloc_delay, delay_size_in, init_delay_in, pipeline_full_reset,
    input  busy, alloc_error, mem_clr_we, mem_clr_addr, mem_clr_data,
    input  desc_we, desc_pipeline, desc_index, desc_base, desc_size, desc_init
  );

  modport slave (
    input  alloc_delay, delay_size_in, init_delay_in, pipeline_full_reset,
    output busy, alloc_error, mem_clr_we, mem_clr_addr, mem_clr_data,
    output desc_we, desc_pipeline, desc_index, desc_base, desc_size, desc_init
  );

endinterface

// File: rtl/delay_allocator_clear_engine.sv
// Walks a freshly carved region, emitting one zeroing write per cycle from
// base upward; done is high during the final write.
module delay_allocator_clear_engine #(
  parameter int MEM_ADDR_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      abort,
  input  logic [MEM_ADDR_WIDTH-1:0] base,
  input  logic [MEM_ADDR_WIDTH-1:0] len,
  output logic                      we,
  output logic [MEM_ADDR_WIDTH-1:0] addr,
  output logic                      done
);

  logic [MEM_ADDR_WIDTH-1:0] remaining;

  assign done = we && (remaining == MEM_ADDR_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      we        <= 1'b0;
      addr      <= '0;
      remaining <= '0;
    end else if (abort) begin
      we        <= 1'b0;
      remaining <= '0;
    end else if (start) begin
      we        <= 1'b1;
      addr      <= base;
      remaining <= len;
    end else if (we) begin
      if (remaining == MEM_ADDR_WIDTH'(1)) begin
        we <= 1'b0;
      end else begin
        addr      <= addr + MEM_ADDR_WIDTH'(1);
        remaining <= remaining - MEM_ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/delay_allocator.sv
// Carves delay-line regions out of the shared delay RAM (one half per
// pipeline), zeroes each region and emits one descriptor per allocation.
module delay_allocator
  import delay_allocator_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = DELAY_MEM_ADDR_WIDTH,
  parameter int N_DELAYS       = DELAY_N_DELAYS,
  parameter int DATA_WIDTH     = DELAY_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  delay_allocator_if.slave  bus,
  output alloc_state_t      dbg_state
);

  localparam int HALF  = 2 ** (MEM_ADDR_WIDTH - 1);
  localparam int CNT_W = $clog2(N_DELAYS + 1);
  localparam int IDX_W = (N_DELAYS > 1) ? $clog2(N_DELAYS) : 1;

  alloc_state_t              state;
  logic                      p_q;
  logic [31:0]               size_q;
  logic [31:0]               init_q;
  logic [MEM_ADDR_WIDTH-1:0] base_q;
  logic [MEM_ADDR_WIDTH-1:0] free_ptr [2];
  logic [CNT_W-1:0]          count    [2];

  logic                      req_ok;
  logic                      abort_job;
  logic                      clr_start;
  logic                      clr_done;
  logic [MEM_ADDR_WIDTH-1:0] clr_base;

  assign dbg_state         = state;
  assign bus.mem_clr_data  = DATA_WIDTH'(0);
  assign abort_job         = (state != IDLE) && bus.pipeline_full_reset[p_q];
  assign clr_base          = (p_q ? MEM_ADDR_WIDTH'(HALF) : '0) + free_ptr[p_q];
  assign clr_start         = (state == CHECK) && req_ok && !abort_job;

  // Remaining space is computed in 32 bits from free_ptr <= HALF, so it never wraps.
  always_comb begin
    req_ok = 1'b1;
    if (size_q == 32'd0)                                       req_ok = 1'b0;
    if (size_q > (32'(HALF) - 32'(free_ptr[p_q])))            req_ok = 1'b0;
    if (init_q >= size_q)                                      req_ok = 1'b0;
    if (count[p_q] == CNT_W'(N_DELAYS))                        req_ok = 1'b0;
    if ((size_q >> MEM_ADDR_WIDTH) != 32'd0)                   req_ok = 1'b0;
    if ((init_q >> MEM_ADDR_WIDTH) != 32'd0)                   req_ok = 1'b0;
  end

  delay_allocator_clear_engine #(.MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_clear (
    .clk   (clk),
    .reset (reset),
    .start (clr_start),
    .abort (abort_job),
    .base  (clr_base),
    .len   (MEM_ADDR_WIDTH'(size_q)),
    .we    (bus.mem_clr_we),
    .addr  (bus.mem_clr_addr),
    .done  (clr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      p_q               <= 1'b0;
      size_q            <= '0;
      init_q            <= '0;
      base_q            <= '0;
      bus.busy          <= 1'b0;
      bus.alloc_error   <= 1'b0;
      bus.desc_we       <= 1'b0;
      bus.desc_pipeline <= 1'b0;
      bus.desc_index    <= '0;
      bus.desc_base     <= '0;
      bus.desc_size     <= '0;
      bus.desc_init     <= '0;
      for (int q = 0; q < 2; q++) begin
        free_ptr[q] <= '0;
        count[q]    <= '0;
      end
    end else begin
      bus.alloc_error <= 1'b0;
      bus.desc_we     <= 1'b0;
      if (state != IDLE && bus.alloc_delay != 2'b00) bus.alloc_error <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.alloc_delay == 2'b01 || bus.alloc_delay == 2'b10) begin
            p_q      <= bus.alloc_delay[1];
            size_q   <= bus.delay_size_in;
            init_q   <= bus.init_delay_in;
            bus.busy <= 1'b1;
            state    <= CHECK;
          end else if (bus.alloc_delay == 2'b11) begin
            bus.alloc_error <= 1'b1;
          end
        end
        CHECK: begin
          if (abort_job) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (!req_ok) begin
            bus.alloc_error <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else begin
            base_q <= clr_base;
            state  <= CLEAR;
          end
        end
        CLEAR: begin
          if (abort_job) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else if (clr_done) begin
            bus.desc_we       <= 1'b1;
            bus.desc_pipeline <= p_q;
            bus.desc_index    <= IDX_W'(count[p_q]);
            bus.desc_base     <= base_q;
            bus.desc_size     <= MEM_ADDR_WIDTH'(size_q);
            bus.desc_init     <= MEM_ADDR_WIDTH'(init_q);
            state             <= DESC;
          end
        end
        DESC: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
          if (!abort_job) begin
            count[p_q]    <= count[p_q] + CNT_W'(1);
            free_ptr[p_q] <= free_ptr[p_q] + MEM_ADDR_WIDTH'(size_q);
          end
        end
        default: state <= IDLE;
      endcase
      // Applied last so a full reset overrides any same-cycle bookkeeping.
      for (int q = 0; q < 2; q++) begin
        if (bus.pipeline_full_reset[q]) begin
          free_ptr[q] <= '0;
          count[q]    <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_delay_allocator.sv
// Directed bench for delay_allocator: expected clear writes, descriptors and
// error pulses are queued by the driver and retired by a negedge monitor.
module tb_delay_allocator;
  import delay_allocator_pkg::*;

  localparam int MAW    = 8;
  localparam int ND     = 16;
  localparam int DW     = 16;
  localparam int DESC_W = 1 + 4 + 3 * MAW;

  logic         clk = 1'b0;
  logic         reset;
  alloc_state_t dbg_state;

  delay_allocator_if #(.MEM_ADDR_WIDTH(MAW), .N_DELAYS(ND), .DATA_WIDTH(DW)) bus ();

  delay_allocator #(.MEM_ADDR_WIDTH(MAW), .N_DELAYS(ND), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [MAW-1:0]    clr_q  [$];
  logic [DESC_W-1:0] desc_q [$];
  logic              err_q  [$];
  int   first_clr_cyc = -1;
  int   last_desc_cyc = -1;
  logic prev_we = 1'b0;
  logic [MAW-1:0]    mon_clr_exp;
  logic [DESC_W-1:0] mon_desc_exp;
  logic [DESC_W-1:0] mon_desc_act;

  function automatic logic [DESC_W-1:0] pack_desc(input logic p, input logic [3:0] idx,
      input logic [MAW-1:0] base, input logic [MAW-1:0] size, input logic [MAW-1:0] init);
    return {p, idx, base, size, init};
  endfunction

  always @(negedge clk) begin
    if (bus.mem_clr_we) begin
      if (!prev_we) first_clr_cyc = cyc;
      checks++;
      if (clr_q.size() == 0) begin
        errors++;
        $display("FAIL clr_unexpected addr=%0d", bus.mem_clr_addr);
      end else begin
        mon_clr_exp = clr_q.pop_front();
        if (bus.mem_clr_addr !== mon_clr_exp || bus.mem_clr_data !== '0) begin
          errors++;
          $display("FAIL clr_write got addr=%0d data=%0h want addr=%0d data=0",
                   bus.mem_clr_addr, bus.mem_clr_data, mon_clr_exp);
        end
      end
    end
    prev_we = bus.mem_clr_we;

    if (bus.desc_we) begin
      last_desc_cyc = cyc;
      checks++;
      mon_desc_act = pack_desc(bus.desc_pipeline, bus.desc_index, bus.desc_base,
                               bus.desc_size, bus.desc_init);
      if (desc_q.size() == 0) begin
        errors++;
        $display("FAIL desc_unexpected got %h", mon_desc_act);
      end else begin
        mon_desc_exp = desc_q.pop_front();
        if (mon_desc_act !== mon_desc_exp) begin
          errors++;
          $display("FAIL desc_write got p=%0d idx=%0d base=%0d size=%0d init=%0d want %h",
                   bus.desc_pipeline, bus.desc_index, bus.desc_base, bus.desc_size,
                   bus.desc_init, mon_desc_exp);
        end
      end
    end

    if (bus.alloc_error) begin
      checks++;
      if (err_q.size() == 0) begin
        errors++;
        $display("FAIL alloc_error_unexpected cyc=%0d", cyc);
      end else begin
        void'(err_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] a, input logic [31:0] size, input logic [31:0] init,
                       output int t);
    @(negedge clk);
    bus.alloc_delay   = a;
    bus.delay_size_in = size;
    bus.init_delay_in = init;
    t = cyc;
    @(negedge clk);
    bus.alloc_delay   = 2'b00;
    bus.delay_size_in = 32'd0;
    bus.init_delay_in = 32'd0;
  endtask

  task automatic pulse_fr(input logic [1:0] q);
    @(negedge clk);
    bus.pipeline_full_reset = q;
    @(negedge clk);
    bus.pipeline_full_reset = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout busy stuck at 1");
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_alloc(input logic p, input int size, input int init,
                              input int base, input int idx);
    for (int i = 0; i < size; i++) clr_q.push_back(MAW'(base + i));
    desc_q.push_back(pack_desc(p, 4'(idx), MAW'(base), MAW'(size), MAW'(init)));
  endtask

  task automatic expect_err();
    err_q.push_back(1'b1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},    32'(bus.busy),        32'd0);
    check({tag, "_err"},     32'(bus.alloc_error), 32'd0);
    check({tag, "_clr_we"},  32'(bus.mem_clr_we),  32'd0);
    check({tag, "_clr_adr"}, 32'(bus.mem_clr_addr),32'd0);
    check({tag, "_desc_we"}, 32'(bus.desc_we),     32'd0);
    check({tag, "_desc"},    32'(pack_desc(bus.desc_pipeline, bus.desc_index, bus.desc_base,
                                           bus.desc_size, bus.desc_init)), 32'd0);
    check({tag, "_state"},   32'(dbg_state),       32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    reset                   = 1'b1;
    bus.alloc_delay         = 2'b00;
    bus.delay_size_in       = 32'd0;
    bus.init_delay_in       = 32'd0;
    bus.pipeline_full_reset = 2'b00;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // 1: p0 size 4 init 2, latency of clears and descriptor
    expect_alloc(1'b0, 4, 2, 0, 0);
    issue(2'b01, 32'd4, 32'd2, t);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_idle();
    check("t1_clr_lat",  32'(first_clr_cyc), 32'(t + 2));
    check("t1_desc_lat", 32'(last_desc_cyc), 32'(t + 6));

    // 2: p1 allocations, then p0 continues from its own pointer
    expect_alloc(1'b1, 8, 0, 128, 0);
    issue(2'b10, 32'd8, 32'd0, t);   wait_idle();
    expect_alloc(1'b1, 16, 15, 136, 1);
    issue(2'b10, 32'd16, 32'd15, t); wait_idle();
    expect_alloc(1'b0, 4, 0, 4, 1);
    issue(2'b01, 32'd4, 32'd0, t);   wait_idle();

    // 3: exact fill of p0, then rejects
    pulse_fr(2'b01);
    expect_alloc(1'b0, 128, 127, 0, 0);
    issue(2'b01, 32'd128, 32'd127, t); wait_idle();
    expect_err(); issue(2'b01, 32'd1, 32'd0, t);          wait_idle();
    expect_err(); issue(2'b10, 32'd0, 32'd0, t);          wait_idle();
    expect_err(); issue(2'b10, 32'd4, 32'd4, t);          wait_idle();
    expect_err(); issue(2'b10, 32'h0001_0002, 32'd0, t);  wait_idle();
    expect_err(); issue(2'b10, 32'd105, 32'd0, t);        wait_idle();
    expect_alloc(1'b1, 104, 103, 152, 2);
    issue(2'b10, 32'd104, 32'd103, t); wait_idle();
    expect_err(); issue(2'b10, 32'd1, 32'd0, t);          wait_idle();
    expect_err(); issue(2'b11, 32'd1, 32'd0, t);          wait_idle();

    // 4: full reset of p0 during CLEAR aborts the job
    pulse_fr(2'b01);
    for (int i = 0; i < 4; i++) clr_q.push_back(MAW'(i));
    issue(2'b01, 32'd20, 32'd0, t);
    repeat (4) @(negedge clk);
    bus.pipeline_full_reset = 2'b01;
    @(negedge clk);
    bus.pipeline_full_reset = 2'b00;
    check("t4_busy_after_abort", 32'(bus.busy), 32'd0);
    check("t4_clr_we_after_abort", 32'(bus.mem_clr_we), 32'd0);
    wait_idle();
    expect_alloc(1'b0, 2, 1, 0, 0);
    issue(2'b01, 32'd2, 32'd1, t); wait_idle();

    // 5: second request during CLEAR is dropped
    expect_alloc(1'b0, 6, 3, 2, 1);
    issue(2'b01, 32'd6, 32'd3, t);
    @(negedge clk);
    expect_err();
    bus.alloc_delay   = 2'b10;
    bus.delay_size_in = 32'd1;
    @(negedge clk);
    bus.alloc_delay   = 2'b00;
    bus.delay_size_in = 32'd0;
    wait_idle();

    // 6: descriptor table exhaustion on p1, then reset during DESC
    pulse_fr(2'b10);
    for (int i = 0; i < ND; i++) begin
      expect_alloc(1'b1, 1, 0, 128 + i, i);
      issue(2'b10, 32'd1, 32'd0, t); wait_idle();
    end
    expect_err(); issue(2'b10, 32'd1, 32'd0, t); wait_idle();

    expect_alloc(1'b0, 1, 0, 8, 2);
    issue(2'b01, 32'd1, 32'd0, t);
    @(negedge clk);
    @(negedge clk);
    check("t6_desc_we_before_reset", 32'(bus.desc_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_desc_reset");
    reset = 1'b0;
    @(negedge clk);
    expect_alloc(1'b0, 3, 1, 0, 0);
    issue(2'b01, 32'd3, 32'd1, t); wait_idle();

    repeat (4) @(negedge clk);
    check("clr_q_drained",  32'(clr_q.size()),  32'd0);
    check("desc_q_drained", 32'(desc_q.size()), 32'd0);
    check("err_q_drained",  32'(err_q.size()),  32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
